// File: rtl/multicycle_memory.sv
// multicycle_memory: word-addressed 16-bit memory, fully pipelined reads with fixed LATENCY
module multicycle_memory #(
  parameter int LATENCY = 4,
  parameter int ADDR_W = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);
  logic [15:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic rd, busy_n, unused;
  logic [LATENCY-1:0] vld, vn;
  logic [15:0] dat [LATENCY];
  logic [15:0] dn [LATENCY];
  assign idx = addr[ADDR_W:1];
  assign rd = enable & ~wr;
  assign unused = ^{addr[0], addr >> (ADDR_W + 1)};
  assign data_valid = vld[LATENCY-1];
  assign data_out = dat[LATENCY-1];
  // vn/dn are the next contents of each stage; busy excludes the stage being presented
  always_comb begin
    busy_n = 1'b0;
    vn[0] = rd;
    dn[0] = mem[idx];
    for (int i = 1; i < LATENCY; i++) begin
      vn[i] = vld[i-1];
      dn[i] = dat[i-1];
    end
    for (int i = 0; i < LATENCY - 1; i++) busy_n = busy_n | vn[i];
  end
  always_ff @(posedge clk)
    if (enable & wr) mem[idx] <= data_in;
  // data stages load only on valid so the output stage holds its last response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld <= '0;
      busy <= 1'b0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else begin
      vld <= vn;
      busy <= busy_n;
      for (int i = 0; i < LATENCY; i++) if (vn[i]) dat[i] <= dn[i];
    end
endmodule
